pipe_controller: RTL and testbench
==================================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter OP_WIDTH, default 7, opcode width.
REQ-002 Parameter ALUCTRL_WIDTH, default 4, ALU control width.
REQ-003 Parameter MULDIV_CYCLES, default 4, E-stage occupancy of a mul/div op; legal range 2..16.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 op  in  OP_WIDTH  D-stage opcode.
REQ-007 funct3  in  3  D-stage funct3.
REQ-008 funct7b5, funct7b0  in  1 each  D-stage funct7 bits 5 and 0.
REQ-009 ZeroE, LtE, LtuE  in  1 each  E-stage ALU flags: equal, signed less-than, unsigned less-than.
REQ-010 FlushE  in  1  clear the D->E control register.
REQ-011 ImmSrcD  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-012 ALUSrcE, ALUControlE[ALUCTRL_WIDTH], MulDivE  out  E-stage controls.
REQ-013 PCSrcE, PCJalSrcE  out  1 each  redirect taken; redirect is JALR.
REQ-014 ResultSrcE0  out  1  E-stage load flag for external load-use detection.
REQ-015 BusyE  out  1  mul/div occupying E; the hazard unit stalls F/D on it.
REQ-016 MemWriteM, RegWriteM  out  1 each; RegWriteW out 1; ResultSrcW out 2 (00 ALU, 01 mem, 10 PC+4).

Function
REQ-017 Decode shall be combinational in D: load, store, R, I-ALU, branch, JAL, JALR, LUI and AUIPC. Any other opcode shall decode to RegWrite=0, MemWrite=0, Branch=0, Jump=0.
REQ-018 Branch condition in E, from pipelined funct3: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE; 010 and 011 never taken.
REQ-019 PCSrcE = (BranchE & taken) | JumpE.
REQ-020 PCJalSrcE shall be derived from the E-stage JALR flag, not the D-stage opcode.
REQ-021 ALU control shall use the package encoding: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB.
REQ-022 SUB shall be selected only for R-type with funct7b5=1; SRA shall be selected when funct3=101 and funct7b5=1.
REQ-023 Pipeline registers D->E, E->M and M->W; latency from D to W is 3 cycles when not stalled.
REQ-024 FSM states IDLE and BUSY.
 - IDLE->BUSY when a mul/div op enters E; the counter loads MULDIV_CYCLES-1.
 - BUSY: decrement the counter each cycle; on counter==1 return to IDLE.
 - BusyE=1 in every cycle the op occupies E except the last.
REQ-025 While BusyE=1: the D->E register holds, and E->M takes a bubble (RegWrite=0, MemWrite=0).
REQ-026 FlushE has priority over hold; FlushE in BUSY shall clear D->E and force IDLE in the same edge.
REQ-027 A cleared or bubbled stage shall have all control outputs 0.

Reset
REQ-028 Reset shall zero all pipeline control registers and return the FSM to IDLE with counter 0.
REQ-029 Reset mid-BUSY shall abandon the operation; BusyE=0 in the cycle after reset.

Configuration
REQ-030 Macro PIPE_CTRL_MULDIV_EN.
 - Defined: R-type with funct7b0=1 decodes as mul/div with MulDivE=1, and the REQ-024 FSM is present.
 - Undefined: funct7b0 is ignored, MulDivE and BusyE are tied 0, and no FSM or counter logic is generated.

Structure
REQ-031 Package pipe_ctrl_pkg shall hold opcode constants, the ImmSrc and ResultSrc encodings, the ALU control enum, and the FSM state typedef.
REQ-032 One sub-module, pipe_ctrl_decode, shall be the combinational D-stage decoder. Pipeline registers and the FSM shall live in pipe_controller.

Verification
REQ-033 op=0110011, funct3=000, funct7b5=1 -> ALUControlE=SUB one cycle later, RegWriteW=1 three cycles later.
REQ-034 Branch funct3=100 with LtE=1 -> PCSrcE=1. Same with LtE=0 -> PCSrcE=0. funct3=010 -> PCSrcE=0 regardless of flags.
REQ-035 JALR in D followed by ADD -> PCJalSrcE=1 only in the JALR's E cycle, and ResultSrcW=10.
REQ-036 MULDIV_CYCLES=4, macro defined, MUL issued -> BusyE=1 for 3 cycles, RegWriteM=0 for those 3 cycles, then the MUL reaches M.
REQ-037 FlushE asserted in the 2nd BUSY cycle -> next cycle BusyE=0, all E outputs 0, FSM in IDLE.
REQ-038 Reset asserted while a store is in E -> MemWriteM=0 and RegWriteW=0 after the edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the pipeline controller: RV32 opcode constants,
//   immediate-format and result-select encodings, the ALU control enum,
//   the mul/div occupancy FSM state type, and small decode helpers.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } aluCtrlT;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdStateT;

  // Control bundle carried from D into E.
  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       aluSrc;
    logic [3:0] aluControl;
    logic [2:0] funct3;
  } ctrlT;

  // Control bundle carried from E into M.
  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
  } ctrlMT;

  // ALU operation for R-type and I-type arithmetic. SUB only exists for
  // R-type; for I-type funct7b5 is an immediate bit except on shifts.
  function automatic aluCtrlT aluFromFunct3(input logic [2:0] funct3,
                                            input logic funct7b5,
                                            input logic isR);
    aluCtrlT sel;
    case (funct3)
      3'b000:  sel = (isR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

  function automatic logic branchTaken(input logic [2:0] funct3,
                                       input logic zero,
                                       input logic lt,
                                       input logic ltu);
    logic taken;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode
//   Combinational D-stage instruction decoder.
//   Optional feature macro: PIPE_CTRL_MULDIV_EN (adds funct7b0 / mulDiv).
// Ports
//   op, funct3, funct7b5     in   D-stage instruction fields
//   funct7b0                 in   (PIPE_CTRL_MULDIV_EN) mul/div select bit
//   mulDiv                   out  (PIPE_CTRL_MULDIV_EN) R-type mul/div op
//   regWrite, memWrite       out  writeback / store enables
//   resultSrc[1:0]           out  00 ALU, 01 mem, 10 PC+4
//   jump, branch, jalr       out  control-flow class
//   aluSrc                   out  ALU B operand is the immediate
//   aluControl[3:0]          out  ALU operation (aluCtrlT encoding)
//   immSrc[2:0]              out  immediate format
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 7
) (
  input  logic [OP_WIDTH-1:0] op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
`ifdef PIPE_CTRL_MULDIV_EN
  input  logic                funct7b0,
  output logic                mulDiv,
`endif
  output logic                regWrite,
  output logic [1:0]          resultSrc,
  output logic                memWrite,
  output logic                jump,
  output logic                branch,
  output logic                jalr,
  output logic                aluSrc,
  output logic [3:0]          aluControl,
  output logic [2:0]          immSrc
);

  aluCtrlT aluSel;
  logic    isAluOp;
  logic    isR;

  always_comb begin
    regWrite  = 1'b0;
    resultSrc = RES_ALU;
    memWrite  = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    jalr      = 1'b0;
    aluSrc    = 1'b0;
    immSrc    = IMM_I;
    aluSel    = ALU_ADD;
    isAluOp   = 1'b0;
    isR       = 1'b0;
`ifdef PIPE_CTRL_MULDIV_EN
    mulDiv    = 1'b0;
`endif
    case (op)
      OP_WIDTH'(OP_LOAD): begin
        regWrite  = 1'b1;
        resultSrc = RES_MEM;
        aluSrc    = 1'b1;
      end
      OP_WIDTH'(OP_STORE): begin
        memWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = IMM_S;
      end
      OP_WIDTH'(OP_R): begin
        regWrite = 1'b1;
        isAluOp  = 1'b1;
        isR      = 1'b1;
      end
      OP_WIDTH'(OP_I): begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        isAluOp  = 1'b1;
      end
      OP_WIDTH'(OP_BRANCH): begin
        branch = 1'b1;
        immSrc = IMM_B;
      end
      OP_WIDTH'(OP_JAL): begin
        regWrite  = 1'b1;
        jump      = 1'b1;
        resultSrc = RES_PC4;
        immSrc    = IMM_J;
      end
      OP_WIDTH'(OP_JALR): begin
        regWrite  = 1'b1;
        jump      = 1'b1;
        jalr      = 1'b1;
        resultSrc = RES_PC4;
        aluSrc    = 1'b1;
      end
      OP_WIDTH'(OP_LUI): begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = IMM_U;
        aluSel   = ALU_PASSB;
      end
      OP_WIDTH'(OP_AUIPC): begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = IMM_U;
      end
      default: ;
    endcase

    if (isAluOp) begin
      aluSel = aluFromFunct3(funct3, funct7b5, isR);
    end

`ifdef PIPE_CTRL_MULDIV_EN
    // Mul/div has its own unit; the ALU result is unused, so keep it at ADD.
    if (isR && funct7b0) begin
      mulDiv = 1'b1;
      aluSel = ALU_ADD;
    end
`endif
  end

  assign aluControl = aluSel;

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller
//   Pipelined control path: D-stage decode, D->E, E->M and M->W control
//   registers, E-stage branch resolution, and (optionally) the mul/div
//   occupancy FSM that holds E for MULDIV_CYCLES cycles.
//   Optional feature macro: PIPE_CTRL_MULDIV_EN.
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   op, funct3, funct7b5, funct7b0     D-stage instruction fields
//   ZeroE, LtE, LtuE                   E-stage ALU compare flags
//   FlushE                             clear the D->E control register
//   ImmSrcD                            D-stage immediate format
//   ALUSrcE, ALUControlE, MulDivE      E-stage datapath controls
//   PCSrcE, PCJalSrcE                  redirect taken / redirect is JALR
//   ResultSrcE0                        E-stage load flag (load-use hazard)
//   BusyE                              mul/div holding E; stall F/D
//   MemWriteM, RegWriteM               M-stage enables
//   RegWriteW, ResultSrcW              W-stage writeback controls
//
// Mul/div FSM
//   state   | meaning
//   ST_IDLE | no multi-cycle op in progress; a mul/div arriving in E starts one
//   ST_BUSY | mul/div occupying E; count is cycles left including this one
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_WIDTH      = 7,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     funct7b0,
  input  logic                     ZeroE,
  input  logic                     LtE,
  input  logic                     LtuE,
  input  logic                     FlushE,
  output logic [2:0]               ImmSrcD,
  output logic                     ALUSrcE,
  output logic [ALUCTRL_WIDTH-1:0] ALUControlE,
  output logic                     MulDivE,
  output logic                     PCSrcE,
  output logic                     PCJalSrcE,
  output logic                     ResultSrcE0,
  output logic                     BusyE,
  output logic                     MemWriteM,
  output logic                     RegWriteM,
  output logic                     RegWriteW,
  output logic [1:0]               ResultSrcW
);

  if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 16) begin : gBadCycles
    $error("pipe_controller: MULDIV_CYCLES must be in 2..16");
  end

  ctrlT  ctrlD;
  ctrlT  ctrlE;
  ctrlMT ctrlM;
  logic  busyE;
  logic  regWriteW;
  logic  [1:0] resultSrcW;

  // ---------------------------------------------------------------- decode
`ifdef PIPE_CTRL_MULDIV_EN
  logic mulDivD;
  logic mulDivE;
`else
  logic unusedFunct7b0;
  assign unusedFunct7b0 = funct7b0;
`endif

  pipe_ctrl_decode #(
    .OP_WIDTH(OP_WIDTH)
  ) uDecode (
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
`ifdef PIPE_CTRL_MULDIV_EN
    .funct7b0  (funct7b0),
    .mulDiv    (mulDivD),
`endif
    .regWrite  (ctrlD.regWrite),
    .resultSrc (ctrlD.resultSrc),
    .memWrite  (ctrlD.memWrite),
    .jump      (ctrlD.jump),
    .branch    (ctrlD.branch),
    .jalr      (ctrlD.jalr),
    .aluSrc    (ctrlD.aluSrc),
    .aluControl(ctrlD.aluControl),
    .immSrc    (ImmSrcD)
  );

  assign ctrlD.funct3 = funct3;

  // ---------------------------------------------------------------- D -> E
  // Flush wins over the mul/div hold so a redirect can kill a long op.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrlE <= '0;
`ifdef PIPE_CTRL_MULDIV_EN
      mulDivE <= 1'b0;
`endif
    end else if (!busyE) begin
      ctrlE <= ctrlD;
`ifdef PIPE_CTRL_MULDIV_EN
      mulDivE <= mulDivD;
`endif
    end
  end

  // ---------------------------------------------------------------- E -> M
  // While E is held, M sees a bubble each cycle so the op retires once.
  always_ff @(posedge clk) begin
    if (reset || busyE) begin
      ctrlM <= '0;
    end else begin
      ctrlM.regWrite  <= ctrlE.regWrite;
      ctrlM.resultSrc <= ctrlE.resultSrc;
      ctrlM.memWrite  <= ctrlE.memWrite;
    end
  end

  // ---------------------------------------------------------------- M -> W
  always_ff @(posedge clk) begin
    if (reset) begin
      regWriteW  <= 1'b0;
      resultSrcW <= RES_ALU;
    end else begin
      regWriteW  <= ctrlM.regWrite;
      resultSrcW <= ctrlM.resultSrc;
    end
  end

  // ---------------------------------------------------------------- mul/div FSM
`ifdef PIPE_CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_CYCLES);

  mdStateT           state;
  mdStateT           nextState;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  nextCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  always_comb begin
    nextState = state;
    nextCount = count;
    if (FlushE) begin
      nextState = ST_IDLE;
      nextCount = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mulDivE) begin
            nextState = ST_BUSY;
            nextCount = CNT_W'(MULDIV_CYCLES - 1);
          end
        end
        ST_BUSY: begin
          if (count == CNT_W'(1)) begin
            nextState = ST_IDLE;
            nextCount = '0;
          end else begin
            nextCount = count - CNT_W'(1);
          end
        end
        default: begin
          nextState = ST_IDLE;
          nextCount = '0;
        end
      endcase
    end
  end

  // The op's first E cycle is spent in IDLE, so busy is asserted there too;
  // the count==1 cycle is the last and lets E advance.
  always_comb begin
    busyE = 1'b0;
    case (state)
      ST_IDLE: busyE = mulDivE;
      ST_BUSY: busyE = (count != CNT_W'(1));
      default: busyE = 1'b0;
    endcase
  end

  assign MulDivE = mulDivE;
`else
  assign busyE   = 1'b0;
  assign MulDivE = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  assign BusyE       = busyE;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign ALUControlE = ALUCTRL_WIDTH'(ctrlE.aluControl);
  assign PCSrcE      = (ctrlE.branch & branchTaken(ctrlE.funct3, ZeroE, LtE, LtuE))
                     | ctrlE.jump;
  assign PCJalSrcE   = ctrlE.jalr;
  assign ResultSrcE0 = ctrlE.resultSrc[0];
  assign MemWriteM   = ctrlM.memWrite;
  assign RegWriteM   = ctrlM.regWrite;
  assign RegWriteW   = regWriteW;
  assign ResultSrcW  = resultSrcW;

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;
  import pipe_ctrl_pkg::*;

  localparam int MDC = 4;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, funct7b0;
  logic       ZeroE, LtE, LtuE, FlushE;
  logic [2:0] ImmSrcD;
  logic       ALUSrcE;
  logic [3:0] ALUControlE;
  logic       MulDivE, PCSrcE, PCJalSrcE, ResultSrcE0, BusyE;
  logic       MemWriteM, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcW;

  int tests = 0;
  int fails = 0;

  pipe_controller #(
    .OP_WIDTH(7), .ALUCTRL_WIDTH(4), .MULDIV_CYCLES(MDC)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .funct7b0(funct7b0),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MulDivE(MulDivE), .PCSrcE(PCSrcE), .PCJalSrcE(PCJalSrcE),
    .ResultSrcE0(ResultSrcE0), .BusyE(BusyE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5, f7b0, zero, lt, ltu;
    logic [2:0] imm;
    logic       aluSrc;
    logic [3:0] alu;
    logic       pcSrc, jalr, load, memWrite, regWrite;
    logic [1:0] res;
  } vecT;

  vecT vecs[$];
  vecT qE[$];
  vecT qM[$];
  vecT qW[$];

  function automatic vecT mk(string n, logic [6:0] o, logic [2:0] f3, logic b5, logic b0,
                             logic z, logic l, logic lu, logic [2:0] imm, logic as,
                             logic [3:0] alu, logic pc, logic jr, logic ld, logic mw,
                             logic rw, logic [1:0] res);
    vecT v;
    v.name = n; v.op = o; v.f3 = f3; v.f7b5 = b5; v.f7b0 = b0;
    v.zero = z; v.lt = l; v.ltu = lu; v.imm = imm; v.aluSrc = as; v.alu = alu;
    v.pcSrc = pc; v.jalr = jr; v.load = ld; v.memWrite = mw; v.regWrite = rw; v.res = res;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [6:0] o, logic [2:0] f3, logic b5, logic b0);
    op = o; funct3 = f3; funct7b5 = b5; funct7b0 = b0;
  endtask

  task automatic drain();
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    vecT v;
    vecT e;
    int  cnt;

    reset = 1'b1; FlushE = 1'b0;
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    drive(OP_STORE, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    tick(); tick();

    // reset state: store in D, nothing may leak past the cleared registers
    check("rst.ALUSrcE", int'(ALUSrcE), 0);
    check("rst.ALUControlE", int'(ALUControlE), 0);
    check("rst.PCSrcE", int'(PCSrcE), 0);
    check("rst.PCJalSrcE", int'(PCJalSrcE), 0);
    check("rst.ResultSrcE0", int'(ResultSrcE0), 0);
    check("rst.BusyE", int'(BusyE), 0);
    check("rst.MulDivE", int'(MulDivE), 0);
    check("rst.MemWriteM", int'(MemWriteM), 0);
    check("rst.RegWriteM", int'(RegWriteM), 0);
    check("rst.RegWriteW", int'(RegWriteW), 0);
    check("rst.ResultSrcW", int'(ResultSrcW), 0);
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    reset = 1'b0;

    //          name     op         f3      b5 b0 z  l  lu imm  as alu        pc jr ld mw rw res
    vecs.push_back(mk("add",   OP_R,      3'b000, 0, 0, 0, 0, 0, IMM_I, 0, ALU_ADD,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("sub",   OP_R,      3'b000, 1, 0, 0, 0, 0, IMM_I, 0, ALU_SUB,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("addi7", OP_I,      3'b000, 1, 0, 0, 0, 0, IMM_I, 1, ALU_ADD,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("srai",  OP_I,      3'b101, 1, 0, 0, 0, 0, IMM_I, 1, ALU_SRA,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("srl",   OP_R,      3'b101, 0, 0, 0, 0, 0, IMM_I, 0, ALU_SRL,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("sra",   OP_R,      3'b101, 1, 0, 0, 0, 0, IMM_I, 0, ALU_SRA,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("sll",   OP_R,      3'b001, 0, 0, 0, 0, 0, IMM_I, 0, ALU_SLL,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("slti",  OP_I,      3'b010, 0, 0, 0, 0, 0, IMM_I, 1, ALU_SLT,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("sltu",  OP_R,      3'b011, 0, 0, 0, 0, 0, IMM_I, 0, ALU_SLTU,  0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("xor",   OP_R,      3'b100, 0, 0, 0, 0, 0, IMM_I, 0, ALU_XOR,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("ori",   OP_I,      3'b110, 0, 0, 0, 0, 0, IMM_I, 1, ALU_OR,    0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("and",   OP_R,      3'b111, 0, 0, 0, 0, 0, IMM_I, 0, ALU_AND,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("lw",    OP_LOAD,   3'b010, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD,   0, 0, 1, 0, 1, RES_MEM));
    vecs.push_back(mk("sw",    OP_STORE,  3'b010, 0, 0, 0, 0, 0, IMM_S, 1, ALU_ADD,   0, 0, 0, 1, 0, RES_ALU));
    vecs.push_back(mk("beqT",  OP_BRANCH, 3'b000, 0, 0, 1, 0, 0, IMM_B, 0, ALU_ADD,   1, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bneN",  OP_BRANCH, 3'b001, 0, 0, 1, 0, 0, IMM_B, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bltT",  OP_BRANCH, 3'b100, 0, 0, 0, 1, 0, IMM_B, 0, ALU_ADD,   1, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bltN",  OP_BRANCH, 3'b100, 0, 0, 1, 0, 1, IMM_B, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("br010", OP_BRANCH, 3'b010, 0, 0, 1, 1, 1, IMM_B, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("br011", OP_BRANCH, 3'b011, 0, 0, 1, 1, 1, IMM_B, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bgeN",  OP_BRANCH, 3'b101, 0, 0, 0, 1, 0, IMM_B, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bgeT",  OP_BRANCH, 3'b101, 0, 0, 0, 0, 1, IMM_B, 0, ALU_ADD,   1, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bltuT", OP_BRANCH, 3'b110, 0, 0, 0, 0, 1, IMM_B, 0, ALU_ADD,   1, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bgeuT", OP_BRANCH, 3'b111, 0, 0, 0, 1, 0, IMM_B, 0, ALU_ADD,   1, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("jal",   OP_JAL,    3'b000, 0, 0, 0, 0, 0, IMM_J, 0, ALU_ADD,   1, 0, 0, 0, 1, RES_PC4));
    vecs.push_back(mk("jalr",  OP_JALR,   3'b000, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD,   1, 1, 0, 0, 1, RES_PC4));
    vecs.push_back(mk("add2",  OP_R,      3'b000, 0, 0, 0, 0, 0, IMM_I, 0, ALU_ADD,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("lui",   OP_LUI,    3'b000, 0, 0, 0, 0, 0, IMM_U, 1, ALU_PASSB, 0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("auipc", OP_AUIPC,  3'b000, 0, 0, 0, 0, 0, IMM_U, 1, ALU_ADD,   0, 0, 0, 0, 1, RES_ALU));
    vecs.push_back(mk("bad7f", 7'h7f,     3'b000, 0, 0, 1, 1, 1, IMM_I, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
    vecs.push_back(mk("bad00", 7'h00,     3'b000, 0, 0, 1, 1, 1, IMM_I, 0, ALU_ADD,   0, 0, 0, 0, 0, RES_ALU));
`ifndef PIPE_CTRL_MULDIV_EN
    vecs.push_back(mk("mulOff", OP_R,     3'b000, 0, 1, 0, 0, 0, IMM_I, 0, ALU_ADD,   0, 0, 0, 0, 1, RES_ALU));
`endif

    // scoreboard: each vector flows D -> E -> M -> W through the queues
    for (int i = 0; i < vecs.size() + 3; i++) begin
      if (qW.size() > 0) begin
        e = qW.pop_front();
        check({e.name, ".RegWriteW"}, int'(RegWriteW), int'(e.regWrite));
        check({e.name, ".ResultSrcW"}, int'(ResultSrcW), int'(e.res));
      end
      if (qM.size() > 0) begin
        e = qM.pop_front();
        check({e.name, ".MemWriteM"}, int'(MemWriteM), int'(e.memWrite));
        check({e.name, ".RegWriteM"}, int'(RegWriteM), int'(e.regWrite));
        qW.push_back(e);
      end
      if (qE.size() > 0) begin
        e = qE.pop_front();
        ZeroE = e.zero; LtE = e.lt; LtuE = e.ltu;
        #1;
        check({e.name, ".ALUSrcE"}, int'(ALUSrcE), int'(e.aluSrc));
        check({e.name, ".ALUControlE"}, int'(ALUControlE), int'(e.alu));
        check({e.name, ".PCSrcE"}, int'(PCSrcE), int'(e.pcSrc));
        check({e.name, ".PCJalSrcE"}, int'(PCJalSrcE), int'(e.jalr));
        check({e.name, ".ResultSrcE0"}, int'(ResultSrcE0), int'(e.load));
        check({e.name, ".MulDivE"}, int'(MulDivE), 0);
        check({e.name, ".BusyE"}, int'(BusyE), 0);
        qM.push_back(e);
      end
      if (i < vecs.size()) begin
        v = vecs[i];
        drive(v.op, v.f3, v.f7b5, v.f7b0);
        #1;
        check({v.name, ".ImmSrcD"}, int'(ImmSrcD), int'(v.imm));
        qE.push_back(v);
      end else begin
        drive(7'b0, 3'b0, 1'b0, 1'b0);
      end
      tick();
    end
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

    // reset while a store sits in E and an ADD sits in M
    drain();
    drive(OP_R, 3'b000, 1'b0, 1'b0);
    tick();
    drive(OP_STORE, 3'b010, 1'b0, 1'b0);
    tick();
    check("rstSt.RegWriteM.pre", int'(RegWriteM), 1);
    reset = 1'b1;
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    tick();
    check("rstSt.MemWriteM", int'(MemWriteM), 0);
    check("rstSt.RegWriteW", int'(RegWriteW), 0);
    check("rstSt.RegWriteM", int'(RegWriteM), 0);
    reset = 1'b0;

`ifdef PIPE_CTRL_MULDIV_EN
    // MUL occupancy: busy for MDC-1 cycles, M bubbled, then MUL retires
    drain();
    drive(OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    drive(OP_R, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < MDC - 1; k++) begin
      check($sformatf("mul.BusyE%0d", k), int'(BusyE), 1);
      check($sformatf("mul.MulDivE%0d", k), int'(MulDivE), 1);
      check($sformatf("mul.RegWriteM%0d", k), int'(RegWriteM), 0);
      tick();
    end
    check("mul.BusyLast", int'(BusyE), 0);
    check("mul.MulDivLast", int'(MulDivE), 1);
    check("mul.RegWriteMLast", int'(RegWriteM), 0);
    tick();
    check("mul.RegWriteMRetire", int'(RegWriteM), 1);
    check("mul.NextMulDivE", int'(MulDivE), 0);
    check("mul.NextBusyE", int'(BusyE), 0);
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    tick();
    check("mul.RegWriteW", int'(RegWriteW), 1);

    // FlushE in the second busy cycle
    drain();
    drive(OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    drive(OP_I, 3'b000, 1'b0, 1'b0);
    check("fl.Busy1", int'(BusyE), 1);
    tick();
    check("fl.Busy2", int'(BusyE), 1);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    check("fl.BusyE", int'(BusyE), 0);
    check("fl.MulDivE", int'(MulDivE), 0);
    check("fl.ALUSrcE", int'(ALUSrcE), 0);
    check("fl.ALUControlE", int'(ALUControlE), 0);
    check("fl.PCSrcE", int'(PCSrcE), 0);
    check("fl.PCJalSrcE", int'(PCJalSrcE), 0);
    check("fl.ResultSrcE0", int'(ResultSrcE0), 0);
    drive(OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 20 && BusyE; k++) begin
      cnt++;
      tick();
    end
    check("fl.NextMulBusyCycles", cnt, MDC - 1);

    // reset in the middle of a busy op
    drain();
    drive(OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    drive(7'b0, 3'b0, 1'b0, 1'b0);
    tick();
    check("rstMd.BusyPre", int'(BusyE), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstMd.BusyE", int'(BusyE), 0);
    check("rstMd.MulDivE", int'(MulDivE), 0);
    tick();
    check("rstMd.BusyAfter", int'(BusyE), 0);
`else
    // without the feature funct7b0 changes nothing and busy never rises
    drain();
    drive(OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    check("noMd.BusyE", int'(BusyE), 0);
    check("noMd.MulDivE", int'(MulDivE), 0);
    check("noMd.ALUControlE", int'(ALUControlE), int'(ALU_ADD));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
